// File: rtl/fetch_queue.sv
// fetch_queue: decoupling buffer between the fetch and decode stages.
// It holds {pc, instr} pairs in FIFO order and presents the head to decode
// through a valid/ready handshake. A synchronous flush discards every entry.
// When the queue is empty the head outputs read as a NOP bubble (all zeros).
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int PW    = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_valid,
  input  logic [31:0]   f_pc,
  input  logic [31:0]   f_instr,
  output logic          f_ready,
  output logic          d_valid,
  input  logic          d_ready,
  output logic [31:0]   d_pc,
  output logic [31:0]   d_pc8,
  output logic [31:0]   d_instr,
  input  logic          flush,
  output logic [PW:0]   occ
);

  localparam logic [PW:0] LP_DEPTH = (PW+1)'(DEPTH);

  logic [31:0]   r_pc    [DEPTH];
  logic [31:0]   r_instr [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Handshake qualifiers; flush overrides both sides of the queue.
  always_comb begin
    w_full  = (r_count == LP_DEPTH);
    w_empty = (r_count == '0);
    w_push  = f_valid & ~w_full & ~flush;
    w_pop   = ~w_empty & d_ready & ~flush;
  end

  // Entry storage: written only on an accepted push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (w_push) begin
      r_pc[r_wp]    <= f_pc;
      r_instr[r_wp] <= f_instr;
    end
  end

  // Pointers and occupancy; flush realigns wp onto rp rather than zeroing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wp    <= r_rp;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presentation; an empty queue shows a zero bubble.
  always_comb begin
    f_ready = ~w_full;
    d_valid = ~w_empty;
    occ     = r_count;
    if (w_empty) begin
      d_pc    = '0;
      d_pc8   = '0;
      d_instr = '0;
    end else begin
      d_pc    = r_pc[r_rp];
      d_pc8   = r_pc[r_rp] + 32'd8;
      d_instr = r_instr[r_rp];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a reference queue tracks accepted entries and is
// compared against the head outputs every cycle; popped pcs are logged so
// ordering can be checked per scenario.
module tb_fetch_queue;

  localparam int DEPTH = 2;
  localparam int PW    = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          f_valid = 1'b0;
  logic [31:0]   f_pc = '0;
  logic [31:0]   f_instr = '0;
  logic          f_ready;
  logic          d_valid;
  logic          d_ready = 1'b0;
  logic [31:0]   d_pc;
  logic [31:0]   d_pc8;
  logic [31:0]   d_instr;
  logic          flush = 1'b0;
  logic [PW:0]   occ;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] obs_log[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          m_n;
  ent_t        m_e;

  fetch_queue #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk(clk), .reset(reset),
    .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_ready(f_ready),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_pc(d_pc), .d_pc8(d_pc8), .d_instr(d_instr),
    .flush(flush), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge.
  task automatic cyc(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                     input logic dr, input logic fl);
    @(posedge clk);
    #1;
    f_valid = fv;
    f_pc    = pc;
    f_instr = ins;
    d_ready = dr;
    flush   = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic chk_log(input string tag, input logic [31:0] exp[$]);
    chk({tag, "_len"}, 32'(obs_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < obs_log.size(); i++)
      chk({tag, "_pc"}, obs_log[i], exp[i]);
  endtask

  // Mid-cycle monitor: compares the head against the reference queue, then
  // advances the reference using the inputs that the next edge will see.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_d_valid", 32'(d_valid), 32'd0);
      chk("rst_occ", 32'(occ), 32'd0);
      chk("rst_f_ready", 32'(f_ready), 32'd1);
      exp_q.delete();
    end else begin
      m_n = exp_q.size();
      chk("d_valid", 32'(d_valid), 32'(m_n != 0));
      chk("f_ready", 32'(f_ready), 32'(m_n != DEPTH));
      chk("occ", 32'(occ), 32'(m_n));
      if (m_n != 0) begin
        m_e = exp_q[0];
        chk("d_pc", d_pc, m_e.pc);
        chk("d_pc8", d_pc8, m_e.pc + 32'd8);
        chk("d_instr", d_instr, m_e.instr);
      end else begin
        chk("bubble_pc", d_pc, 32'h0);
        chk("bubble_pc8", d_pc8, 32'h0);
        chk("bubble_instr", d_instr, 32'h0);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_n != 0 && d_ready) begin
          obs_log.push_back(exp_q[0].pc);
          void'(exp_q.pop_front());
        end
        if (f_valid && m_n != DEPTH) exp_q.push_back('{f_pc, f_instr});
      end
    end
  end

  initial begin
    int          sent;
    int          budget;
    logic [31:0] exp_l[$];

    // Reset state at time zero.
    #1;
    chk("init_d_valid", 32'(d_valid), 32'd0);
    chk("init_d_instr", d_instr, 32'h0);
    chk("init_occ", 32'(occ), 32'd0);
    chk("init_f_ready", 32'(f_ready), 32'd1);
    @(negedge clk);
    #1 reset = 1'b1;

    // Single pass.
    obs_log.delete();
    cyc(1'b1, 32'h3000, 32'h24080001, 1'b1, 1'b0);
    idle(3);
    exp_l = '{32'h3000};
    chk_log("single", exp_l);

    // Stall until full; the third push must be refused.
    obs_log.delete();
    cyc(1'b1, 32'h3000, 32'hA0000000, 1'b0, 1'b0);
    cyc(1'b1, 32'h3004, 32'hA0000004, 1'b0, 1'b0);
    cyc(1'b1, 32'h3008, 32'hA0000008, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(4);
    exp_l = '{32'h3000, 32'h3004};
    chk_log("full", exp_l);

    // Simultaneous push and pop at occupancy 1 streams without gaps.
    obs_log.delete();
    cyc(1'b1, 32'h3000, 32'hB0000000, 1'b1, 1'b0);
    cyc(1'b1, 32'h3004, 32'hB0000004, 1'b1, 1'b0);
    cyc(1'b1, 32'h3008, 32'hB0000008, 1'b1, 1'b0);
    idle(3);
    exp_l = '{32'h3000, 32'h3004, 32'h3008};
    chk_log("stream", exp_l);

    // Flush with concurrent push and ready: everything dropped.
    obs_log.delete();
    cyc(1'b1, 32'h3000, 32'hC0000000, 1'b0, 1'b0);
    cyc(1'b1, 32'h3004, 32'hC0000004, 1'b0, 1'b0);
    cyc(1'b1, 32'h3010, 32'hC0000010, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h3020, 32'hC0000020, 1'b1, 1'b0);
    idle(3);
    exp_l = '{32'h3020};
    chk_log("flush", exp_l);

    // Asynchronous reset mid-stream with two entries held.
    cyc(1'b1, 32'h4000, 32'hD0000000, 1'b0, 1'b0);
    cyc(1'b1, 32'h4004, 32'hD0000004, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_d_valid", 32'(d_valid), 32'd0);
    chk("arst_d_instr", d_instr, 32'h0);
    chk("arst_d_pc", d_pc, 32'h0);
    chk("arst_occ", 32'(occ), 32'd0);
    chk("arst_f_ready", 32'(f_ready), 32'd1);
    @(negedge clk);
    #1 reset = 1'b1;
    obs_log.delete();
    cyc(1'b1, 32'h3000, 32'h24080001, 1'b1, 1'b0);
    idle(3);
    exp_l = '{32'h3000};
    chk_log("post_rst", exp_l);

    // Wrap-around under random decode stalls.
    obs_log.delete();
    sent   = 0;
    budget = 0;
    while ((sent < 7 || exp_q.size() != 0) && budget < 300) begin
      @(posedge clk);
      #1;
      budget++;
      d_ready = 1'($urandom_range(0, 1));
      flush   = 1'b0;
      if (sent < 7 && f_ready) begin
        f_valid = 1'b1;
        f_pc    = 32'h3000 + 32'(sent * 4);
        f_instr = 32'hE0000000 + 32'(sent);
        sent++;
      end else begin
        f_valid = 1'b0;
      end
    end
    if (budget >= 300) chk("wrap_timeout", 32'(budget), 32'd0);
    idle(2);
    exp_l = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3014, 32'h3018};
    chk_log("wrap", exp_l);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling instruction buffer between the fetch stage (PC/IM/PC+4) and the decode stage of the 5-stage MIPS pipeline.
- Captures {pc, instr} pairs from fetch and presents them in order to decode via a valid/ready handshake.
- Absorbs decode stalls without losing in-flight instructions.
- Supports a synchronous flush for redirects and exceptions, and emits a NOP bubble when empty.

Parameters:
- DEPTH, 2, number of entries; power of 2, minimum 2.
- PW, 1, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- f_valid  input  1  fetch presents a valid instruction.
- f_pc  input  32  PC of the fetched instruction.
- f_instr  input  32  fetched instruction word.
- f_ready  output  1  queue can accept an entry this cycle.
- d_valid  output  1  head entry valid for decode.
- d_ready  input  1  decode accepts head this cycle (not stalled).
- d_pc  output  32  PC of head entry.
- d_pc8  output  32  d_pc + 8 (link address for jal/jalr).
- d_instr  output  32  instruction word of head entry.
- flush  input  1  synchronous discard of all entries.
- occ  output  PW+1  current entry count, 0..DEPTH.

Behaviour:
- Storage: DEPTH entries of {pc[31:0], instr[31:0]}, plus write pointer wp[PW-1:0], read pointer rp[PW-1:0] and count[PW:0].
- Reset (reset==0, asynchronous, any time):
  - count=0, wp=0, rp=0, all storage=0.
  - Outputs immediately: d_valid=0, d_pc=0, d_pc8=0, d_instr=0, f_ready=1, occ=0.
- Release: leaving reset is synchronous to clk; the first push can occur at the first rising edge after reset goes high.
- Derived signals (combinational):
  - f_ready = (count != DEPTH). No dependence on d_ready; a full queue does not accept a push even if a pop occurs the same cycle.
  - d_valid = (count != 0).
  - push = f_valid & f_ready & ~flush.
  - pop = d_valid & d_ready & ~flush.
- Head outputs when count != 0: d_pc = pc[rp], d_instr = instr[rp], d_pc8 = pc[rp] + 32'd8 (modulo 2^32).
- Head outputs when count == 0: d_instr = 32'h00000000 (NOP bubble), d_pc = 0, d_pc8 = 0.
- Rising edge with flush=1:
  - Highest priority after reset: count=0, wp=rp (pointers aligned, values not reset).
  - Storage contents unchanged but unreachable.
  - Concurrent f_valid is dropped; d_ready is ignored.
- Rising edge with flush=0:
  - push: storage[wp] <= {f_pc, f_instr}; wp <= wp+1 (wraps DEPTH-1 -> 0).
  - pop: rp <= rp+1 (wraps).
  - count <= count + push - pop. Push and pop together leave count unchanged.
- Latency: an entry pushed at edge N is visible at d_* after edge N (no fall-through from f_* to d_*). Minimum fetch-to-decode latency is 1 cycle.
- Ordering: strict FIFO; no entry is duplicated or reordered across pointer wrap.
- Head stability: while d_valid=1 and d_ready=0, d_pc, d_pc8 and d_instr hold stable.
- occ = count.

Test Plan:
- Reset: hold reset=0 mid-stream with 2 entries loaded -> immediately d_valid=0, d_instr=0, occ=0, f_ready=1; after release, first push at pc=0x3000 appears at d_pc one cycle later.
- Single pass: push {0x3000, 0x24080001}, d_ready=1 -> next cycle d_valid=1, d_pc=0x3000, d_pc8=0x3008, d_instr=0x24080001; following cycle d_valid=0, d_instr=0.
- Stall/full: d_ready=0, push 0x3000 and 0x3004 -> occ=2, f_ready=0; further push of 0x3008 ignored; set d_ready=1 -> outputs 0x3000 then 0x3004, then f_ready=1.
- Simultaneous push/pop at occ=1: occ stays 1; outputs stream 0x3000, 0x3004, 0x3008 on consecutive cycles with no gaps.
- Flush: occ=2, assert flush with f_valid=1 (pc 0x3010) and d_ready=1 -> next cycle occ=0, d_valid=0, 0x3010 not enqueued; a push after that appears normally.
- Wrap-around: 7 push/pop pairs with pcs 0x3000..0x3018 under random d_ready stalls -> decode observes all 7 pcs in order, none lost or duplicated, d_pc8 = d_pc+8 each time.
